// File: rtl/instr_fetch.sv
// instr_fetch: in-order instruction fetch with credit-limited request issue, a DEPTH-entry
// instruction FIFO and redirect flush. Define FETCH_BYPASS_EN for a 0-cycle response bypass.
module instr_fetch #(
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [31:0]       imem_rsp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [31:0]       instr_word,
  output logic [ADDR_W-1:0] instr_pc
);
  localparam int                DATA_W    = 32;
  localparam int                PW        = $clog2(DEPTH);
  localparam int                CW        = $clog2(DEPTH + 1);
  localparam logic [DATA_W-1:0] NOOP_WORD = 32'hF000_0000;
  localparam logic [CW:0]       CREDITS   = (CW+1)'(DEPTH);
  localparam logic [CW-1:0]     FULL      = CW'(DEPTH);
  localparam logic [ADDR_W-1:0] PC_STEP   = ADDR_W'(4);

  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:2], 2'b00};
  endfunction

  logic [ADDR_W-1:0] pc_p0;
  logic [ADDR_W-1:0] flight_pc_p1 [DEPTH];
  logic [PW-1:0]     flight_rd, flight_wr;
  logic [DATA_W-1:0] fifo_word_p2 [DEPTH];
  logic [ADDR_W-1:0] fifo_pc_p2   [DEPTH];
  logic [PW-1:0]     rd_ptr, wr_ptr;
  logic [CW-1:0]     count, outstanding, drop;

  logic [CW:0]       used;
  logic              req_fire, rsp_fire, rsp_live, push, pop, bypass, vld_p2;
  logic [ADDR_W-1:0] rsp_pc;
  logic              unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // p0: request issue against the shared FIFO/in-flight credit pool
  assign used           = {1'b0, count} + {1'b0, outstanding};
  assign imem_req_valid = !rst && !redirect_valid && (used < CREDITS);
  assign imem_req_addr  = pc_p0;
  assign req_fire       = imem_req_valid && imem_req_ready;

  // p1: response capture; responses with nothing owed are stray and ignored
  assign rsp_fire = imem_rsp_valid && (outstanding != '0);
  assign rsp_live = rsp_fire && (drop == '0);
  assign rsp_pc   = flight_pc_p1[flight_rd];
  assign vld_p2   = (count != '0);

`ifdef FETCH_BYPASS_EN
  assign bypass = rsp_live && !vld_p2 && !redirect_valid;
`else
  assign bypass = 1'b0;
`endif

  assign push = rsp_live && !redirect_valid && !(bypass && instr_ready);
  assign pop  = vld_p2 && instr_ready && !redirect_valid;

  // p2: decode handoff from FIFO head, or straight from memory when bypassing
  assign instr_valid = vld_p2 || bypass;

  always_comb begin
    instr_word = NOOP_WORD;
    instr_pc   = '0;
    if (vld_p2) begin
      instr_word = fifo_word_p2[rd_ptr];
      instr_pc   = fifo_pc_p2[rd_ptr];
    end else if (bypass) begin
      instr_word = imem_rsp_data;
      instr_pc   = rsp_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_p0       <= RESET_PC;
      flight_rd   <= '0;
      flight_wr   <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(rsp_fire);
      if (req_fire) begin
        pc_p0     <= pc_p0 + PC_STEP;
        flight_wr <= flight_wr + PW'(1);
      end
      if (rsp_fire) flight_rd <= flight_rd + PW'(1);
      if (redirect_valid) begin
        pc_p0  <= align_pc(redirect_pc);
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
        // outstanding already includes responses queued for discard, so this
        // covers both the carried drop and the newly stale live requests
        drop   <= outstanding - CW'(rsp_fire);
      end else begin
        if (push) wr_ptr <= wr_ptr + PW'(1);
        if (pop)  rd_ptr <= rd_ptr + PW'(1);
        count <= count + CW'(push) - CW'(pop);
        if (rsp_fire && (drop != '0)) drop <= drop - CW'(1);
      end
      assert (!(push && !pop && (count == FULL)));
      assert (used <= CREDITS);
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) flight_pc_p1[flight_wr] <= pc_p0;
    if (push) begin
      fifo_word_p2[wr_ptr] <= imem_rsp_data;
      fifo_pc_p2[wr_ptr]   <= rsp_pc;
    end
  end
endmodule

// File: tb/tb_instr_fetch.sv
// Directed vector table plus randomized in-order memory stream for instr_fetch (RESET_PC=0x100).
module tb_instr_fetch;
  localparam int ADDR_W = 32;
  localparam int DEPTH  = 4;
  localparam logic [31:0] NOOP = 32'hF000_0000;
`ifdef FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              imem_req_valid, imem_req_ready;
  logic [ADDR_W-1:0] imem_req_addr;
  logic              imem_rsp_valid;
  logic [31:0]       imem_rsp_data;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              instr_valid, instr_ready;
  logic [31:0]       instr_word;
  logic [ADDR_W-1:0] instr_pc;

  always #5 clk = ~clk;

  instr_fetch #(.ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(32'h100)) dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_word(instr_word), .instr_pc(instr_pc)
  );

  // rsp/redir/enb/eby: 0 means "none"; enb/eby are the expected instr_pc without/with bypass
  typedef struct {
    logic rst, rr;
    logic [31:0] rsp, redir;
    logic ir, erv;
    logic [31:0] era, enb, eby;
  } vec_t;
  typedef struct { logic [31:0] addr; int due; } pend_t;

  vec_t  tbl[$];
  pend_t rq[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] wof(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  task automatic add(input logic r, input logic rr, input logic [31:0] rsp, input logic [31:0] redir,
                     input logic ir, input logic erv, input logic [31:0] era,
                     input logic [31:0] enb, input logic [31:0] eby);
    vec_t v;
    v.rst = r; v.rr = rr; v.rsp = rsp; v.redir = redir; v.ir = ir;
    v.erv = erv; v.era = era; v.enb = enb; v.eby = eby;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %h expected %h", nm, row, act, exp);
    end
  endtask

  initial begin
    logic [31:0] ip, exp_pc, exp_req, hs_addr;
    logic        hs, rdy_t;
    int          edge_n, last_due, accepted, consumed, due;

    rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    redirect_valid = 1'b0; redirect_pc = '0; instr_ready = 1'b0;

    //   rst rr rsp     redir   ir erv era     enb     eby
    add(1, 0, 0,      0,      1, 0, 'h100, 0,      0);
    add(0, 1, 0,      0,      1, 1, 'h100, 0,      0);
    add(0, 1, 'h100,  0,      1, 1, 'h104, 0,      'h100);
    add(0, 1, 'h104,  0,      1, 1, 'h108, 'h100,  'h104);
    add(0, 0, 'h108,  0,      1, 1, 'h10C, 'h104,  'h108);
    add(0, 0, 0,      0,      1, 1, 'h10C, 'h108,  0);
    add(0, 1, 0,      0,      0, 1, 'h10C, 0,      0);
    add(0, 1, 'h10C,  0,      0, 1, 'h110, 0,      'h10C);
    add(0, 1, 'h110,  0,      0, 1, 'h114, 'h10C,  'h10C);
    add(0, 1, 'h114,  0,      0, 1, 'h118, 'h10C,  'h10C);
    add(0, 1, 'h118,  0,      0, 0, 'h11C, 'h10C,  'h10C);
    add(0, 1, 0,      0,      1, 0, 'h11C, 'h10C,  'h10C);
    add(0, 1, 0,      0,      0, 1, 'h11C, 'h110,  'h110);
    add(0, 1, 'h11C,  0,      0, 0, 'h120, 'h110,  'h110);
    add(0, 0, 0,      0,      1, 0, 'h120, 'h110,  'h110);
    add(0, 1, 0,      0,      1, 1, 'h120, 'h114,  'h114);
    add(0, 1, 0,      0,      1, 1, 'h124, 'h118,  'h118);
    add(0, 1, 'h120,  'h203,  1, 0, 'h128, 'h11C,  'h11C);
    add(0, 1, 0,      0,      1, 1, 'h200, 0,      0);
    add(0, 1, 'h124,  0,      1, 1, 'h204, 0,      0);
    add(0, 0, 'h200,  0,      1, 1, 'h208, 0,      'h200);
    add(0, 0, 'h204,  0,      1, 1, 'h208, 'h200,  'h204);
    add(0, 0, 0,      0,      1, 1, 'h208, 'h204,  0);
    add(0, 1, 0,      0,      1, 1, 'h208, 0,      0);
    add(0, 1, 0,      0,      1, 1, 'h20C, 0,      0);
    add(0, 1, 0,      'h303,  1, 0, 'h210, 0,      0);
    add(0, 1, 'h208,  0,      1, 1, 'h300, 0,      0);
    add(0, 0, 'h20C,  0,      1, 1, 'h304, 0,      0);
    add(0, 0, 0,      0,      1, 1, 'h304, 0,      0);
    add(0, 0, 'h300,  0,      1, 1, 'h304, 0,      'h300);
    add(0, 0, 0,      0,      1, 1, 'h304, 'h300,  0);
    add(0, 1, 0,      0,      0, 1, 'h304, 0,      0);
    add(0, 1, 0,      0,      0, 1, 'h308, 0,      0);
    add(0, 1, 'h304,  0,      0, 1, 'h30C, 0,      'h304);
    add(0, 1, 'h308,  0,      0, 1, 'h310, 'h304,  'h304);
    add(0, 1, 0,      0,      0, 0, 'h314, 'h304,  'h304);
    add(1, 1, 'h30C,  0,      0, 0, 'h314, 'h304,  'h304);
    add(0, 0, 'h310,  0,      0, 1, 'h100, 0,      0);
    add(0, 1, 0,      0,      1, 1, 'h100, 0,      0);
    add(0, 0, 'h100,  0,      1, 1, 'h104, 0,      'h100);
    add(0, 0, 0,      0,      1, 1, 'h104, 'h100,  0);
    add(0, 0, 0,      0,      1, 1, 'h104, 0,      0);

    foreach (tbl[i]) begin
      @(posedge clk); #1;
      rst            = tbl[i].rst;
      imem_req_ready = tbl[i].rr;
      imem_rsp_valid = (tbl[i].rsp != 0);
      imem_rsp_data  = (tbl[i].rsp != 0) ? wof(tbl[i].rsp) : 32'h0;
      redirect_valid = (tbl[i].redir != 0);
      redirect_pc    = tbl[i].redir;
      instr_ready    = tbl[i].ir;
      @(negedge clk);
      ip = BYP ? tbl[i].eby : tbl[i].enb;
      chk("req_valid",   i, 32'(imem_req_valid), 32'(tbl[i].erv));
      chk("req_addr",    i, imem_req_addr, tbl[i].era);
      chk("instr_valid", i, 32'(instr_valid), 32'(ip != 0));
      chk("instr_word",  i, instr_word, (ip != 0) ? wof(ip) : NOOP);
      chk("instr_pc",    i, instr_pc, ip);
    end

    // Random stream: toggling req_ready, latency 1-5, random instr_ready
    @(posedge clk); #1;
    rst = 1'b1; imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; redirect_valid = 1'b0; instr_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    hs = 1'b0; hs_addr = '0; rdy_t = 1'b0; edge_n = 0; last_due = 0;
    accepted = 0; consumed = 0; exp_pc = 32'h100; exp_req = 32'h100;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      edge_n++;
      if (hs) begin
        due = edge_n + int'($urandom_range(1, 5));
        if (due <= last_due) due = last_due + 1;
        rq.push_back('{addr: hs_addr, due: due});
        last_due = due;
        accepted++;
      end
      if (rq.size() != 0 && rq[0].due <= edge_n + 1) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = wof(rq[0].addr);
        void'(rq.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
      end
      rdy_t          = !rdy_t;
      imem_req_ready = rdy_t;
      instr_ready    = 1'($urandom_range(0, 1));
      @(negedge clk);
      hs      = imem_req_valid && imem_req_ready;
      hs_addr = imem_req_addr;
      chk("credit", c, 32'((accepted - consumed) <= DEPTH), 32'd1);
      if (hs) begin
        chk("rand_req_addr", c, hs_addr, exp_req);
        exp_req += 4;
      end
      if (instr_valid) begin
        if (instr_ready) begin
          chk("stream_pc",   c, instr_pc, exp_pc);
          chk("stream_word", c, instr_word, wof(exp_pc));
          exp_pc += 4;
          consumed++;
        end
      end else begin
        chk("idle_word", c, instr_word, NOOP);
        chk("idle_pc",   c, instr_pc, 32'h0);
      end
    end
    chk("progress", 0, 32'(consumed >= 40), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
